mips_mc_controller: RTL and testbench

Multi-cycle MIPS control unit: a Moore state machine plus ALU decoder that sequences each instruction through fetch, decode, execute, memory and writeback. It sits directly upstream of the ALU and drives its 4-bit `ALUCtrl` using the same encoding: ADD 0010, SUB 0110, AND 0000, OR 0001, SLT 0111. It consumes the ALU `Zero` flag to resolve `beq` and drives every enable and mux select in the multi-cycle datapath.

---
 rtl/mips_mc_controller.sv | 175 +++++++++++++++++
 tb/tb_mips_mc_controller.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_mc_controller.sv
// Multi-cycle MIPS control FSM (Moore) with ALU decoder driving datapath enables/selects.
// Latency: outputs combinational from state (PCEn also from Zero); state advances each clk.
// Backpressure: none; one state per cycle, no stalls or flow control.
module mips_mc_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] Op,
    input  logic [5:0] Funct,
    input  logic       Zero,
    output logic       PCEn,
    output logic       IorD,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSrc,
    output logic [3:0] ALUCtrl,
    output logic [3:0] State,
    output logic       IllegalOp
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEX   = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11
    } state_t;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    state_t     state;
    state_t     next_state;
    logic       pcwrite;
    logic       branch;
    logic [1:0] aluop;

    // State register; reset aborts any in-flight instruction immediately
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= S_FETCH;
        else
            state <= next_state;
    end

    // Next-state and per-state Moore outputs; everything defaults to 0
    always_comb begin
        next_state = S_FETCH;
        pcwrite    = 1'b0;
        branch     = 1'b0;
        aluop      = 2'b00;
        IorD       = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        RegDst     = 1'b0;
        MemtoReg   = 1'b0;
        RegWrite   = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        PCSrc      = 2'b00;
        IllegalOp  = 1'b0;
        case (state)
            S_FETCH: begin
                ALUSrcB    = 2'b01;
                IRWrite    = 1'b1;
                pcwrite    = 1'b1;
                next_state = S_DECODE;
            end
            S_DECODE: begin
                // Branch target computed speculatively here
                ALUSrcB = 2'b11;
                case (Op)
                    OP_LW, OP_SW: next_state = S_MEMADR;
                    OP_RTYPE:     next_state = S_EXECUTE;
                    OP_BEQ:       next_state = S_BRANCH;
                    OP_ADDI:      next_state = S_ADDIEX;
                    OP_J:         next_state = S_JUMP;
                    default: begin
                        // Unsupported opcode retires as a NOP
                        next_state = S_FETCH;
                        IllegalOp  = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                next_state = (Op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                IorD       = 1'b1;
                next_state = S_MEMWB;
            end
            S_MEMWB: begin
                MemtoReg = 1'b1;
                RegWrite = 1'b1;
            end
            S_MEMWRITE: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
            end
            S_EXECUTE: begin
                ALUSrcA    = 1'b1;
                aluop      = 2'b10;
                next_state = S_ALUWB;
            end
            S_ALUWB: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA = 1'b1;
                aluop   = 2'b01;
                PCSrc   = 2'b01;
                branch  = 1'b1;
            end
            S_ADDIEX: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                next_state = S_ADDIWB;
            end
            S_ADDIWB: begin
                RegWrite = 1'b1;
            end
            S_JUMP: begin
                PCSrc   = 2'b10;
                pcwrite = 1'b1;
            end
            default: begin
                // Unused encodings: all strobes low, recover to FETCH
                next_state = S_FETCH;
            end
        endcase
    end

    // ALU decoder; unknown combinations fall back to ADD so ALUCtrl is never X
    always_comb begin
        ALUCtrl = 4'b0010;
        case (aluop)
            2'b00: ALUCtrl = 4'b0010;
            2'b01: ALUCtrl = 4'b0110;
            2'b10: begin
                case (Funct)
                    6'b100000: ALUCtrl = 4'b0010;
                    6'b100010: ALUCtrl = 4'b0110;
                    6'b100100: ALUCtrl = 4'b0000;
                    6'b100101: ALUCtrl = 4'b0001;
                    6'b101010: ALUCtrl = 4'b0111;
                    default:   ALUCtrl = 4'b0010;
                endcase
            end
            default: ALUCtrl = 4'b0010;
        endcase
    end

    // Zero only matters while Branch is high, i.e. in BRANCH
    assign PCEn  = pcwrite | (branch & Zero);
    assign State = state;

endmodule

// File: tb/tb_mips_mc_controller.sv
// Bench for mips_mc_controller: table of instructions plus randomized instruction stream.
// Latency: checks sampled 1ns after the falling edge, away from the rising clock edge.
// Backpressure: not applicable.
module tb_mips_mc_controller;

    logic       clk;
    logic       reset;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic [3:0] aluctrl, state;
    logic       illegalop;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic       pcen;
        logic       iord;
        logic       memwrite;
        logic       irwrite;
        logic       regdst;
        logic       memtoreg;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic [3:0] aluctrl;
        logic [3:0] state;
        logic       illegal;
    } outs_t;

    typedef struct {
        string      name;
        logic [5:0] op;
        logic [5:0] funct;
        int         zmode;   // 0: Zero=0, 1: Zero=1, 2: random per cycle
        int         cycles;
    } vec_t;

    typedef int iq_t[$];

    mips_mc_controller dut (
        .clk       (clk),
        .reset     (reset),
        .Op        (op),
        .Funct     (funct),
        .Zero      (zero),
        .PCEn      (pcen),
        .IorD      (iord),
        .MemWrite  (memwrite),
        .IRWrite   (irwrite),
        .RegDst    (regdst),
        .MemtoReg  (memtoreg),
        .RegWrite  (regwrite),
        .ALUSrcA   (alusrca),
        .ALUSrcB   (alusrcb),
        .PCSrc     (pcsrc),
        .ALUCtrl   (aluctrl),
        .State     (state),
        .IllegalOp (illegalop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic outs_t get_outs();
        outs_t o;
        o = '{pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
              alusrcb, pcsrc, aluctrl, state, illegalop};
        return o;
    endfunction

    // Sequence of states an instruction visits, by opcode
    function automatic iq_t model_path(input logic [5:0] o);
        iq_t p;
        case (o)
            6'b100011: p = '{0, 1, 2, 3, 4};
            6'b101011: p = '{0, 1, 2, 5};
            6'b000000: p = '{0, 1, 6, 7};
            6'b000100: p = '{0, 1, 8};
            6'b001000: p = '{0, 1, 9, 10};
            6'b000010: p = '{0, 1, 11};
            default:   p = '{0, 1};
        endcase
        return p;
    endfunction

    function automatic logic [3:0] rtype_ctrl(input logic [5:0] f);
        case (f)
            6'b100010: return 4'b0110;
            6'b100100: return 4'b0000;
            6'b100101: return 4'b0001;
            6'b101010: return 4'b0111;
            default:   return 4'b0010;
        endcase
    endfunction

    function automatic logic legal_op(input logic [5:0] o);
        return (o == 6'b100011) || (o == 6'b101011) || (o == 6'b000000) ||
               (o == 6'b000100) || (o == 6'b001000) || (o == 6'b000010);
    endfunction

    // Expected outputs for a given architectural step
    function automatic outs_t exp_out(input int st, input logic [5:0] o,
                                      input logic [5:0] f, input logic z);
        outs_t e;
        e = '0;
        e.aluctrl = 4'b0010;
        e.state   = st[3:0];
        case (st)
            0:  begin e.alusrcb = 2'b01; e.irwrite = 1; e.pcen = 1; end
            1:  begin e.alusrcb = 2'b11; e.illegal = !legal_op(o); end
            2:  begin e.alusrca = 1; e.alusrcb = 2'b10; end
            3:  e.iord = 1;
            4:  begin e.memtoreg = 1; e.regwrite = 1; end
            5:  begin e.iord = 1; e.memwrite = 1; end
            6:  begin e.alusrca = 1; e.aluctrl = rtype_ctrl(f); end
            7:  begin e.regdst = 1; e.regwrite = 1; end
            8:  begin e.alusrca = 1; e.pcsrc = 2'b01; e.aluctrl = 4'b0110; e.pcen = z; end
            9:  begin e.alusrca = 1; e.alusrcb = 2'b10; end
            10: e.regwrite = 1;
            11: begin e.pcsrc = 2'b10; e.pcen = 1; end
            default: ;
        endcase
        return e;
    endfunction

    // Runs one instruction starting in FETCH, checks every cycle and the cycle count
    task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input int zmode,
                             input int cyc, input string nm);
        iq_t   path;
        outs_t e;
        int    k;
        path  = model_path(o);
        op    = o;
        funct = f;
        for (k = 0; k < 20; k++) begin
            zero = (zmode == 2) ? 1'($urandom_range(0, 1)) : (zmode == 1);
            #1;
            if (k > 0 && state == 4'd0) break;
            if (k < path.size()) begin
                e = exp_out(path[k], o, f, zero);
                chk({nm, "_outs"}, 32'(get_outs()), 32'(e));
            end else begin
                chk({nm, "_overrun_state"}, 32'(state), 32'd0);
            end
            @(negedge clk);
        end
        chk({nm, "_cycles"}, k, cyc);
    endtask

    vec_t vecs[14];

    initial begin
        outs_t e;
        vecs[0]  = '{"lw",      6'b100011, 6'b000000, 0, 5};
        vecs[1]  = '{"sw",      6'b101011, 6'b000000, 1, 4};
        vecs[2]  = '{"j",       6'b000010, 6'b000000, 1, 3};
        vecs[3]  = '{"addi",    6'b001000, 6'b000000, 0, 4};
        vecs[4]  = '{"r_add",   6'b000000, 6'b100000, 0, 4};
        vecs[5]  = '{"r_sub",   6'b000000, 6'b100010, 1, 4};
        vecs[6]  = '{"r_and",   6'b000000, 6'b100100, 0, 4};
        vecs[7]  = '{"r_or",    6'b000000, 6'b100101, 2, 4};
        vecs[8]  = '{"r_slt",   6'b000000, 6'b101010, 0, 4};
        vecs[9]  = '{"r_unk",   6'b000000, 6'b000111, 0, 4};
        vecs[10] = '{"beq_z1",  6'b000100, 6'b000000, 1, 3};
        vecs[11] = '{"beq_z0",  6'b000100, 6'b000000, 0, 3};
        vecs[12] = '{"illegal", 6'b111111, 6'b000000, 1, 2};
        vecs[13] = '{"beq_rnd", 6'b000100, 6'b101010, 2, 3};

        // Reset state
        reset = 1'b1; op = 6'b111111; funct = 6'b0; zero = 1'b1;
        #3;
        chk("reset_outs", 32'(get_outs()), 32'(exp_out(0, op, funct, zero)));
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("reset_release_state", 32'(state), 32'd0);

        // Zero toggled in FETCH has no effect on PCEn
        zero = 1'b0; #1;
        chk("fetch_zero0_pcen", 32'(pcen), 32'd1);
        zero = 1'b1; #1;
        chk("fetch_zero1_pcen", 32'(pcen), 32'd1);

        // Table of instructions
        foreach (vecs[i])
            run_instr(vecs[i].op, vecs[i].funct, vecs[i].zmode, vecs[i].cycles, vecs[i].name);

        // BRANCH follows Zero combinationally within the cycle
        op = 6'b000100; zero = 1'b0;
        @(negedge clk); @(negedge clk); #1;
        chk("branch_state", 32'(state), 32'd8);
        zero = 1'b1; #1;
        chk("branch_z1_pcen", 32'(pcen), 32'd1);
        zero = 1'b0; #1;
        chk("branch_z0_pcen", 32'(pcen), 32'd0);
        @(negedge clk); #1;
        chk("branch_done_state", 32'(state), 32'd0);

        // Asynchronous reset in the middle of EXECUTE
        op = 6'b000000; funct = 6'b101010; zero = 1'b0;
        @(negedge clk); @(negedge clk); #1;
        chk("rst_exec_state", 32'(state), 32'd6);
        reset = 1'b1; #1;
        chk("rst_async_state", 32'(state), 32'd0);
        chk("rst_async_outs", 32'(get_outs()), 32'(exp_out(0, op, funct, zero)));
        @(posedge clk); #1;
        chk("rst_hold_regwrite", 32'(regwrite), 32'd0);
        chk("rst_hold_state", 32'(state), 32'd0);
        @(negedge clk);
        reset = 1'b0; #1;
        chk("rst_rel_regwrite", 32'(regwrite), 32'd0);
        @(negedge clk); #1;
        chk("rst_next_state", 32'(state), 32'd1);
        for (int i = 0; i < 10 && state != 4'd0; i++) begin
            @(negedge clk); #1;
        end
        chk("rst_drain_state", 32'(state), 32'd0);

        // Randomized instruction stream
        for (int n = 0; n < 80; n++) begin
            logic [5:0] o, f;
            int         sel;
            sel = $urandom_range(0, 7);
            case (sel)
                0: o = 6'b100011;
                1: o = 6'b101011;
                2: o = 6'b000000;
                3: o = 6'b000100;
                4: o = 6'b001000;
                5: o = 6'b000010;
                default: o = 6'($urandom_range(0, 63));
            endcase
            sel = $urandom_range(0, 6);
            case (sel)
                0: f = 6'b100000;
                1: f = 6'b100010;
                2: f = 6'b100100;
                3: f = 6'b100101;
                4: f = 6'b101010;
                default: f = 6'($urandom_range(0, 63));
            endcase
            run_instr(o, f, 2, model_path(o).size(), "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
